// File: rtl/tri_raster_scan.sv
// Triangle scan converter: latches a triangle, sets up its bounding box and edge
// functions, then walks the box row-major emitting covered pixels via valid/ready.
module tri_raster_scan #(
  parameter int COORD_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_in,
  input  logic [6*COORD_W-1:0] tri_in,
  output logic                 rdy_in,
  output logic [COORD_W-1:0]   frag_x,
  output logic [COORD_W-1:0]   frag_y,
  output logic                 vld_out,
  input  logic                 rdy_out,
  output logic                 done
);
  localparam int AW = COORD_W + 1;
  localparam int EW = 2 * COORD_W + 3;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic signed [AW-1:0] coef_t;
  typedef logic signed [EW-1:0] efun_t;
  typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;

  function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic coef_t to_coef(coord_t v);
    return coef_t'({1'b0, v});
  endfunction

  function automatic efun_t to_efun(coord_t v);
    return efun_t'({{(EW-COORD_W){1'b0}}, v});
  endfunction

  function automatic efun_t sext(coef_t c);
    return efun_t'({{(EW-AW){c[AW-1]}}, c});
  endfunction

  // Edge i runs from vertex i to vertex nxt(i): (v0,v1), (v1,v2), (v2,v0).
  function automatic int nxt(int i);
    return (i == 2) ? 0 : i + 1;
  endfunction

  state_t state_q;
  coord_t vx_q [3];
  coord_t vy_q [3];
  coord_t xmin_q, xmax_q, ymax_q, x_q, y_q;
  coef_t  a_q [3];
  coef_t  b_q [3];
  efun_t  e_q [3];
  efun_t  er_q [3];
  logic   degen_q;
  coord_t fx_q, fy_q;
  logic   vld_q, done_q;

  coord_t xmin_d, xmax_d, ymin_d, ymax_d;
  coef_t  a_d [3];
  coef_t  b_d [3];
  efun_t  e_d [3];
  efun_t  d_sum;

  // NOTE: every always_comb output gets a default before any branch or loop, so no latches.
  always_comb begin
    xmin_d = min3(vx_q[0], vx_q[1], vx_q[2]);
    xmax_d = max3(vx_q[0], vx_q[1], vx_q[2]);
    ymin_d = min3(vy_q[0], vy_q[1], vy_q[2]);
    ymax_d = max3(vy_q[0], vy_q[1], vy_q[2]);
    d_sum  = '0;
    for (int i = 0; i < 3; i++) begin
      a_d[i] = to_coef(vy_q[i]) - to_coef(vy_q[nxt(i)]);
      b_d[i] = to_coef(vx_q[nxt(i)]) - to_coef(vx_q[i]);
      e_d[i] = sext(a_d[i]) * to_efun(xmin_d) + sext(b_d[i]) * to_efun(ymin_d)
             + to_efun(vx_q[i]) * to_efun(vy_q[nxt(i)])
             - to_efun(vx_q[nxt(i)]) * to_efun(vy_q[i]);
      d_sum  = d_sum + e_d[i];
    end
  end

  logic all_ge, all_le, covered, adv, row_end, last;

  always_comb begin
    all_ge = 1'b1;
    all_le = 1'b1;
    for (int i = 0; i < 3; i++) begin
      all_ge = all_ge & ~e_q[i][EW-1];
      all_le = all_le & (e_q[i][EW-1] | (e_q[i] == '0));
    end
    covered = ~degen_q & (all_ge | all_le);
    adv     = (state_q == SCAN) && (!covered || !vld_q || rdy_out);
    row_end = (x_q == xmax_q);
    last    = row_end && (y_q == ymax_q);
  end

  // NOTE: the datapath is fully reloaded before use, so only control state is reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && vld_in) begin
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= tri_in[2*i*COORD_W +: COORD_W];
        vy_q[i] <= tri_in[(2*i+1)*COORD_W +: COORD_W];
      end
    end
    if (state_q == SETUP) begin
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymax_q  <= ymax_d;
      x_q     <= xmin_d;
      y_q     <= ymin_d;
      degen_q <= (d_sum == '0);
      for (int i = 0; i < 3; i++) begin
        a_q[i]  <= a_d[i];
        b_q[i]  <= b_d[i];
        e_q[i]  <= e_d[i];
        er_q[i] <= e_d[i];
      end
    end else if (adv) begin
      if (row_end) begin
        x_q <= xmin_q;
        y_q <= y_q + 1'b1;
        for (int i = 0; i < 3; i++) begin
          er_q[i] <= er_q[i] + sext(b_q[i]);
          e_q[i]  <= er_q[i] + sext(b_q[i]);
        end
      end else begin
        x_q <= x_q + 1'b1;
        for (int i = 0; i < 3; i++) e_q[i] <= e_q[i] + sext(a_q[i]);
      end
    end
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE:    if (vld_in) state_q <= SETUP;
        SETUP:   state_q <= SCAN;
        SCAN:    if (adv && last) begin
                   state_q <= IDLE;
                   done_q  <= 1'b1;
                 end
        default: state_q <= IDLE;
      endcase
      if (adv && covered) begin
        fx_q  <= x_q;
        fy_q  <= y_q;
        vld_q <= 1'b1;
      end else if (vld_q && rdy_out) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign rdy_in  = (state_q == IDLE);
  assign frag_x  = fx_q;
  assign frag_y  = fy_q;
  assign vld_out = vld_q;
  assign done    = done_q;

endmodule
